// File: rtl/softmax_pkg.sv
// Shared constants, FSM state type and fp16 helpers for the softmax result
// serializer and its argmax tracker.
package softmax_pkg;

  localparam int DATA_W = 16;
  localparam int N_ELEM = 10;
  localparam int IDX_W  = $clog2(N_ELEM);

  // Wide enough for any pipeline latency in 1..1023.
  localparam int CNT_W  = 10;

  localparam logic [DATA_W-1:0] FP16_ONE  = 16'h3C00;
  localparam logic [DATA_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } ser_state_t;

  // Magnitude field of an fp16 value (sign dropped). Softmax outputs are
  // non-negative, so unsigned ordering of this field is value ordering.
  function automatic logic [DATA_W-2:0] fp16_mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-2:0];
  endfunction

endpackage

// File: rtl/softmax_result_serializer_if.sv
// AXI4-Stream style element stream from the serializer to its consumer.
interface softmax_result_serializer_if #(
  parameter int DATA_W = 16
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/fp16_argmax_tracker.sv
// Running maximum over a stream of non-negative fp16 magnitudes.
// A beat replaces the stored maximum only when strictly greater, so ties keep
// the earlier (lower) index. Only built when SOFTMAX_SER_ARGMAX_EN is defined.
module fp16_argmax_tracker
  import softmax_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              beat_en,
  input  logic [IDX_W-1:0]  beat_idx,
  input  logic [DATA_W-2:0] mag,
  output logic [DATA_W-2:0] max_val,
  output logic [IDX_W-1:0]  max_idx
);

  // Track the largest magnitude seen since the last clear and where it was.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (beat_en && (mag > max_val)) begin
      max_val <= mag;
      max_idx <= beat_idx;
    end
  end

endmodule

// File: rtl/softmax_result_serializer.sv
// Softmax result serializer: waits out the normalizer's fixed latency after
// start, captures the parallel result vector, then streams it one element per
// beat with tlast on the final element.
// Optional argmax reporting is enabled by defining SOFTMAX_SER_ARGMAX_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no vector in flight; a start pulse is accepted here only
// WAIT  | latency down-counter running; capture when it reaches zero
// SEND  | streaming captured elements, index advances on each handshake
module softmax_result_serializer
  import softmax_pkg::*;
#(
  parameter int PIPE_LAT = 40
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     start,
  input  logic [N_ELEM*DATA_W-1:0] res_vec,
  output logic                     busy,
  output logic                     drop_err,
`ifdef SOFTMAX_SER_ARGMAX_EN
  output logic [IDX_W-1:0]         argmax_idx,
  output logic                     argmax_valid,
`endif
  softmax_result_serializer_if.master m_axis
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(PIPE_LAT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  ser_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] vec_q [N_ELEM];

  logic              capture;
  logic              beat;
  logic              last_beat;
  logic              sending;
  logic [DATA_W-1:0] tdata_int;

  assign sending   = (state_q == SEND);
  assign beat      = sending && m_axis.tready;
  assign last_beat = beat && (idx_q == LAST_IDX);

  // State, latency counter and element index registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: accept start in IDLE, count down, then stream.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = LAT_LOAD;
          idx_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SEND: begin
        if (beat) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Snapshot the normalizer outputs at the capture edge only.
  always_ff @(posedge aclk) begin
    if (capture) begin
      for (int k = 0; k < N_ELEM; k++) begin
        vec_q[k] <= res_vec[k*DATA_W +: DATA_W];
      end
    end
  end

  // A start arriving while a vector is in flight is lost; remember that.
  always_ff @(posedge aclk) begin
    if (areset) begin
      drop_err <= 1'b0;
    end else if (start && (state_q != IDLE)) begin
      drop_err <= 1'b1;
    end
  end

  // Stream outputs are decoded from registers only, so they hold during stalls.
  always_comb begin
    tdata_int = FP16_ZERO;
    if (sending) begin
      tdata_int = vec_q[idx_q];
    end
  end

  assign m_axis.tdata  = tdata_int;
  assign m_axis.tvalid = sending;
  assign m_axis.tlast  = sending && (idx_q == LAST_IDX);
  assign busy          = (state_q != IDLE);

`ifdef SOFTMAX_SER_ARGMAX_EN
  logic [DATA_W-2:0] max_val_unused;
  logic [IDX_W-1:0]  max_idx;

  fp16_argmax_tracker u_argmax (
    .clk      (aclk),
    .rst      (areset),
    .clear    (capture),
    .beat_en  (beat),
    .beat_idx (idx_q),
    .mag      (fp16_mag(tdata_int)),
    .max_val  (max_val_unused),
    .max_idx  (max_idx)
  );

  // The tracker has folded in the final beat by the cycle after tlast.
  always_ff @(posedge aclk) begin
    if (areset) begin
      argmax_valid <= 1'b0;
    end else begin
      argmax_valid <= last_beat;
    end
  end

  assign argmax_idx = max_idx;
`endif

endmodule

// File: tb/tb_softmax_result_serializer.sv
// Bench for softmax_result_serializer: directed scenarios, a cycle-level
// behavioural model compared every cycle, and literal timing/data checks.
module tb_softmax_result_serializer;
  import softmax_pkg::*;

  localparam int LAT = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     areset;
  logic                     start;
  logic [N_ELEM*DATA_W-1:0] res_vec;
  logic                     busy;
  logic                     drop_err;
`ifdef SOFTMAX_SER_ARGMAX_EN
  logic [IDX_W-1:0]         argmax_idx;
  logic                     argmax_valid;
`endif

  softmax_result_serializer_if #(.DATA_W(DATA_W)) axis ();

  softmax_result_serializer #(.PIPE_LAT(LAT)) dut (
    .aclk         (clk),
    .areset       (areset),
    .start        (start),
    .res_vec      (res_vec),
    .busy         (busy),
    .drop_err     (drop_err),
`ifdef SOFTMAX_SER_ARGMAX_EN
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid),
`endif
    .m_axis       (axis)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  int          acc_cyc = 0;
  int          cap_at = 0;
  bit          mbusy = 0, mvalid = 0, mdrop = 0, pend = 0;
  int          midx = 0;
  logic [15:0] mvec [N_ELEM];
`ifdef SOFTMAX_SER_ARGMAX_EN
  int          m_am_idx = 0;
  bit          m_am_v = 0;
`endif

  always @(posedge clk) begin
    cyc++;
    if (areset) begin
      mbusy = 0; mvalid = 0; mdrop = 0; pend = 0; midx = 0;
`ifdef SOFTMAX_SER_ARGMAX_EN
      m_am_v = 0;
`endif
    end else begin
`ifdef SOFTMAX_SER_ARGMAX_EN
      m_am_v = 0;
`endif
      if (start) begin
        if (mbusy) mdrop = 1;
        else begin
          mbusy = 1; pend = 1; cap_at = cyc + LAT; acc_cyc = cyc;
        end
      end
      if (mvalid && axis.tready) begin
        if (midx == N_ELEM - 1) begin
          mvalid = 0; mbusy = 0; midx = 0;
`ifdef SOFTMAX_SER_ARGMAX_EN
          m_am_v = 1;
`endif
        end else midx++;
      end
      if (pend && cyc == cap_at) begin
        for (int k = 0; k < N_ELEM; k++) mvec[k] = res_vec[k*16 +: 16];
        pend = 0; mvalid = 1; midx = 0;
`ifdef SOFTMAX_SER_ARGMAX_EN
        m_am_idx = 0;
        for (int k = 1; k < N_ELEM; k++)
          if (mvec[k][14:0] > mvec[m_am_idx][14:0]) m_am_idx = k;
`endif
      end
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(mbusy));
      check("tvalid", 32'(axis.tvalid), 32'(mvalid));
      check("drop_err", 32'(drop_err), 32'(mdrop));
      if (mvalid) begin
        check("tdata", 32'(axis.tdata), 32'(mvec[midx]));
        check("tlast", 32'(axis.tlast), 32'(midx == N_ELEM - 1));
      end
`ifdef SOFTMAX_SER_ARGMAX_EN
      check("argmax_valid", 32'(argmax_valid), 32'(m_am_v));
      if (m_am_v) check("argmax_idx_model", 32'(argmax_idx), m_am_idx);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  int          mode = 0;
  int          ph = 0;
  logic [15:0] exp_vec [N_ELEM];
  logic [15:0] got [N_ELEM];
  int          first_valid, last_rel, fall_rel, hs;
  logic        drop_pre, drop_post, post_valid, post_busy, post_tlast;
  int          am_pulses, am_rel;

  task automatic step();
    @(negedge clk);
    start = 1'b0;
    axis.tready = (mode == 0) ? 1'b1 : ((ph % 3) == 0);
    ph++;
  endtask

  task automatic load_vec(input logic [15:0] base, input int i1, input int i2, input logic [15:0] hi);
    for (int k = 0; k < N_ELEM; k++) begin
      exp_vec[k] = (k == i1 || k == i2) ? hi : base;
      res_vec[k*16 +: 16] = exp_vec[k];
    end
  endtask

  // Runs one stream to completion, recording timing relative to the accepted
  // start (cycle 0 = start sampled). Optional dropped start, mid-stream reset
  // and res_vec swap after capture.
  task automatic watch(input int drop_rel, input int rst_after, input bit swap);
    int rel;
    first_valid = -1; last_rel = -1; fall_rel = -1; hs = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      rel = cyc - acc_cyc + 1;
      if (rel == drop_rel) begin
        drop_pre = drop_err;
        start = 1'b1;
      end
      if (rel == drop_rel + 1) drop_post = drop_err;
      if (swap && rel == LAT + 1) res_vec = {N_ELEM{FP16_ONE}};
`ifdef SOFTMAX_SER_ARGMAX_EN
      if (argmax_valid) begin am_pulses++; am_rel = rel; end
`endif
      if (axis.tvalid && first_valid < 0) first_valid = rel;
      if (axis.tvalid && axis.tready) begin
        if (hs < N_ELEM) got[hs] = axis.tdata;
        if (axis.tlast) last_rel = rel;
        hs++;
        if (hs == rst_after) begin
          step();
          areset = 1'b1;
          step();
          areset = 1'b0;
          post_valid = axis.tvalid; post_busy = busy; post_tlast = axis.tlast;
          return;
        end
      end
      if (!busy && first_valid >= 0) begin
        fall_rel = rel;
        return;
      end
    end
    n_chk++; n_fail++;
    $display("FAIL watch_timeout: stream not finished after 300 cycles (beats=%0d)", hs);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    areset = 1'b1; start = 1'b0; axis.tready = 1'b1; res_vec = '0;
    am_pulses = 0; am_rel = -1;
    repeat (3) step();
    areset = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_tvalid", 32'(axis.tvalid), 0);
    check("rst_tlast", 32'(axis.tlast), 0);
    check("rst_tdata", 32'(axis.tdata), 0);
    check("rst_drop_err", 32'(drop_err), 0);
    chk_en = 1;

    // basic latency and order
    load_vec(16'h2E66, 3, -1, 16'h3800);
    step(); start = 1'b1;
    watch(-1, -1, 0);
    check("t1_first_beat_cycle", first_valid, 41);
    check("t1_tlast_cycle", last_rel, 50);
    check("t1_busy_fall_cycle", fall_rel, 51);
    check("t1_beats", hs, 10);
    check("t1_elem3", 32'(got[3]), 32'h3800);
    check("t1_elem0", 32'(got[0]), 32'h2E66);

    // backpressure 1,0,0,1,...
    mode = 1; ph = 0;
    step(); start = 1'b1;
    watch(-1, -1, 0);
    check("t2_beats", hs, 10);
    for (int k = 0; k < N_ELEM; k++) check("t2_elem", 32'(got[k]), 32'(exp_vec[k]));
    mode = 0;

    // dropped start at cycle 20
    step(); start = 1'b1;
    watch(20, -1, 0);
    check("t3_drop_before", 32'(drop_pre), 0);
    check("t3_drop_after", 32'(drop_post), 1);
    check("t3_first_beat_cycle", first_valid, 41);
    check("t3_beats", hs, 10);
    check("t3_drop_sticky", 32'(drop_err), 1);

    // reset after beat 4
    step(); start = 1'b1;
    watch(-1, 5, 0);
    check("t4_post_tvalid", 32'(post_valid), 0);
    check("t4_post_busy", 32'(post_busy), 0);
    check("t4_post_tlast", 32'(post_tlast), 0);
    check("t4_drop_cleared", 32'(drop_err), 0);
    step(); start = 1'b1;
    watch(-1, -1, 0);
    check("t4_restart_beats", hs, 10);
    check("t4_restart_elem0", 32'(got[0]), 32'(exp_vec[0]));
    check("t4_restart_elem3", 32'(got[3]), 32'h3800);

    // back-to-back with res_vec swap after first capture
    step(); start = 1'b1;
    watch(-1, -1, 1);
    check("t5_first_elem3", 32'(got[3]), 32'h3800);
    check("t5_first_elem9", 32'(got[9]), 32'h2E66);
    start = 1'b1;
    watch(-1, -1, 0);
    check("t5_second_first_beat_cycle", first_valid, 41);
    check("t5_second_beats", hs, 10);
    for (int k = 0; k < N_ELEM; k++) check("t5_second_elem", 32'(got[k]), 32'h3C00);
    check("t5_no_drop", 32'(drop_err), 0);

`ifdef SOFTMAX_SER_ARGMAX_EN
    // argmax with a tie at 2 and 7
    load_vec(16'h2C00, 2, 7, 16'h3A00);
    am_pulses = 0; am_rel = -1;
    step(); start = 1'b1;
    watch(-1, -1, 0);
    repeat (3) begin
      step();
      if (argmax_valid) am_pulses++;
    end
    check("t6_argmax_idx", 32'(argmax_idx), 2);
    check("t6_argmax_pulses", am_pulses, 1);
    check("t6_argmax_pulse_cycle", am_rel, last_rel + 1);
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
